// File: rtl/gpio_debounce.sv
// gpio_debounce: per-bit two-flop synchroniser followed by a stability
// counter. A bit's debounced level only changes after the synchronised
// input has disagreed with it for DebounceCycles consecutive compare edges.
// Accepted changes produce one-cycle rise/fall pulses and a combined
// change flag, all registered.
module gpio_debounce #(
  parameter int                 Width          = 8,
  parameter int                 DebounceCycles = 500000,
  parameter logic [Width-1:0]   ResetValue     = {Width{1'b0}}
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] db_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             change_o
);

  // Counter is wide enough to hold DebounceCycles; the terminal value is
  // DebounceCycles-1, so it can never wrap.
  localparam int                CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0]   CntTerm = CntW'(DebounceCycles - 1);

  logic [Width-1:0] s1_q, s1_d;
  logic [Width-1:0] s2_q, s2_d;
  logic [Width-1:0] db_q, db_d;
  logic [Width-1:0] rise_q, rise_d;
  logic [Width-1:0] fall_q, fall_d;
  logic             change_q, change_d;
  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];

  // Next-state logic: synchroniser shift, per-bit counters and acceptance.
  always_comb begin
    s1_d   = raw_i;
    s2_d   = s1_q;
    db_d   = db_q;
    rise_d = {Width{1'b0}};
    fall_d = {Width{1'b0}};
    for (int i = 0; i < Width; i++) begin
      cnt_d[i] = {CntW{1'b0}};
      if (s2_q[i] == db_q[i]) begin
        // Input agrees with the accepted level: any pending change is void.
        cnt_d[i] = {CntW{1'b0}};
      end else if (cnt_q[i] == CntTerm) begin
        // Disagreement has lasted long enough: accept the new level.
        db_d[i]   = s2_q[i];
        cnt_d[i]  = {CntW{1'b0}};
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    change_d = |(rise_d | fall_d);
  end

  // State registers with synchronous reset; the synchroniser resets to the
  // same value as db so an idle input produces no pulse after release.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      s1_q     <= ResetValue;
      s2_q     <= ResetValue;
      db_q     <= ResetValue;
      rise_q   <= {Width{1'b0}};
      fall_q   <= {Width{1'b0}};
      change_q <= 1'b0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= {CntW{1'b0}};
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign db_o     = db_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Self-checking bench for gpio_debounce (Width=8, DebounceCycles=4).
// The reference model records every applied input and, at each edge,
// asks whether the synchronised input has differed from the debounced
// level over the last DebounceCycles compare edges with no reset in between.
module tb_gpio_debounce;

  localparam int W    = 8;
  localparam int DC   = 4;
  localparam int MAXE = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw;
  logic [W-1:0] db;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         chg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hist [MAXE];
  bit           rsth [MAXE];
  int           e = 0;

  logic [W-1:0] db_m   = 8'h00;
  logic [W-1:0] rise_m = 8'h00;
  logic [W-1:0] fall_m = 8'h00;
  logic         chg_m  = 1'b0;

  gpio_debounce #(
    .Width          (W),
    .DebounceCycles (DC),
    .ResetValue     (8'h00)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .raw_i     (raw),
    .db_o      (db),
    .rise_o    (rise),
    .fall_o    (fall),
    .change_o  (chg)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value the synchroniser presents to the compare at edge ee.
  function automatic logic [W-1:0] sync_at(input int ee);
    if (ee < 2) return 8'h00;
    if (rsth[ee-1] || rsth[ee-2]) return 8'h00;
    return hist[ee-2];
  endfunction

  // One clock: apply inputs, advance the model, compare all outputs.
  task automatic step(input logic [W-1:0] r, input bit rs);
    logic [W-1:0] sv;
    bit           ok;
    int           ee;
    if (e >= MAXE) begin
      $display("FAIL history: edge index %0d exceeds %0d", e, MAXE);
      $fatal(1, "history overflow");
    end
    @(negedge clk);
    raw     = r;
    rst     = rs;
    hist[e] = r;
    rsth[e] = rs;
    @(posedge clk);
    rise_m = 8'h00;
    fall_m = 8'h00;
    if (rs) begin
      db_m = 8'h00;
    end else begin
      for (int i = 0; i < W; i++) begin
        ok = 1'b1;
        for (int j = 0; j < DC; j++) begin
          ee = e - j;
          if (ee < 0 || rsth[ee]) begin
            ok = 1'b0;
          end else begin
            sv = sync_at(ee);
            if (sv[i] == db_m[i]) ok = 1'b0;
          end
        end
        if (ok) begin
          if (db_m[i]) fall_m[i] = 1'b1;
          else         rise_m[i] = 1'b1;
          db_m[i] = ~db_m[i];
        end
      end
    end
    chg_m = |(rise_m | fall_m);
    e++;
    #1;
    check_eq("db",     32'(db),   32'(db_m));
    check_eq("rise",   32'(rise), 32'(rise_m));
    check_eq("fall",   32'(fall), 32'(fall_m));
    check_eq("change", 32'(chg),  32'(chg_m));
  endtask

  initial begin
    int           rcount;
    int           rpos;
    int           den;
    logic [W-1:0] cur;
    logic [W-1:0] flip;
    bit           rs;

    raw = 8'h00;
    rst = 1'b1;

    // Reset, then 20 idle cycles with no pulses.
    for (int k = 0; k < 3; k++) step(8'h00, 1'b1);
    check_eq("reset_db", 32'(db), 32'h0);
    for (int k = 0; k < 20; k++) step(8'h00, 1'b0);

    // Single bit rise: accepted at the sixth edge from capture.
    for (int k = 0; k < 6; k++) begin
      step(8'h01, 1'b0);
      if (k == 4) check_eq("lat_before", 32'(db), 32'h00);
    end
    check_eq("lat_db",   32'(db),   32'h01);
    check_eq("lat_rise", 32'(rise), 32'h01);
    check_eq("lat_chg",  32'(chg),  32'h1);
    step(8'h01, 1'b0);
    check_eq("rise_1cyc", 32'(rise), 32'h00);

    // Short glitch on bit3 is rejected.
    for (int k = 0; k < 3; k++)  step(8'h09, 1'b0);
    for (int k = 0; k < 10; k++) step(8'h01, 1'b0);
    check_eq("glitch_db", 32'(db), 32'h01);

    // Simultaneous rise and fall on different bits.
    for (int k = 0; k < 8; k++) step(8'h80, 1'b0);
    check_eq("pre_simul_db", 32'(db), 32'h80);
    for (int k = 0; k < 6; k++) step(8'h01, 1'b0);
    check_eq("simul_db",   32'(db),   32'h01);
    check_eq("simul_rise", 32'(rise), 32'h01);
    check_eq("simul_fall", 32'(fall), 32'h80);
    check_eq("simul_chg",  32'(chg),  32'h1);
    step(8'h01, 1'b0);
    check_eq("simul_chg_1cyc", 32'(chg), 32'h0);

    // Bouncing bit0 then hold high: one rise, six edges after final capture.
    for (int k = 0; k < 8; k++) step(8'h00, 1'b0);
    rcount = 0;
    rpos   = -1;
    for (int k = 0; k < 20; k++) begin
      step(((k / 2) % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
      if (rise[0]) rcount++;
    end
    for (int k = 0; k < 12; k++) begin
      step(8'h01, 1'b0);
      if (rise[0]) begin
        rcount++;
        rpos = k;
      end
    end
    check_eq("bounce_count", 32'(rcount), 32'd1);
    check_eq("bounce_pos",   32'(rpos),   32'd5);

    // Reset mid-count discards progress; full debounce restarts at release.
    for (int k = 0; k < 8; k++) step(8'h00, 1'b0);
    for (int k = 0; k < 4; k++) step(8'h04, 1'b0);
    step(8'h04, 1'b1);
    check_eq("midrst_db", 32'(db), 32'h00);
    for (int k = 0; k < 8; k++) begin
      step(8'h04, 1'b0);
      if (k == 4) check_eq("midrst_early", 32'(rise[2]), 32'h0);
      if (k == 5) check_eq("midrst_rise",  32'(rise[2]), 32'h1);
    end

    // Randomised phases with differing bounce rates and occasional resets.
    cur = 8'h00;
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0:       den = 2;
        1:       den = 8;
        default: den = 32;
      endcase
      for (int k = 0; k < 400; k++) begin
        flip = 8'h00;
        for (int b = 0; b < W; b++) begin
          if ($urandom_range(den - 1) == 0) flip[b] = 1'b1;
        end
        if ($urandom_range(7) == 0) flip = 8'hFF;
        cur = cur ^ flip;
        rs  = ($urandom_range(299) == 0);
        step(cur, rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter Width, default 8, number of independent input bits (switches and buttons feeding the demo system general-purpose inputs).
REQ-002 SHALL have parameter DebounceCycles, default 500000, the number of consecutive stable cycles required before a change is accepted; legal range 1..2^24.
REQ-003 SHALL have parameter ResetValue, default all zeros, Width bits: reset value of the synchroniser stages and of db_o.
REQ-004 SHALL have port clk_sys_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_sys_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port raw_i, input, Width bits: asynchronous, bouncing pad inputs.
REQ-007 SHALL have port db_o, output, Width bits: registered, debounced level; drives the system gp_i.
REQ-008 SHALL have port rise_o, output, Width bits: one-cycle pulse per bit on an accepted 0->1 change.
REQ-009 SHALL have port fall_o, output, Width bits: one-cycle pulse per bit on an accepted 1->0 change.
REQ-010 SHALL have port change_o, output, 1 bit: registered OR of all rise and fall pulses for the same cycle.

Function
REQ-011 SHALL pass each raw_i bit through a two-flop synchroniser (s1, s2); no other logic SHALL read raw_i.
REQ-012 SHALL keep per bit an independent counter cnt of width $clog2(DebounceCycles+1); no bit SHALL affect another bit's state.
REQ-013 When s2 == db_o[i], cnt[i] SHALL load 0 on the next edge; an interrupted change restarts from 0.
REQ-014 When s2 != db_o[i] and cnt[i] < DebounceCycles-1, cnt[i] SHALL increment by 1.
REQ-015 When s2 != db_o[i] and cnt[i] == DebounceCycles-1, on the same edge: db_o[i] <= s2, cnt[i] <= 0, and rise_o[i] or fall_o[i] <= 1.
REQ-016 Latency SHALL be exact: raw_i held stable from the first capture edge E0 gives db_o update at edge E(DebounceCycles+1), i.e. DebounceCycles+2 edges including E0.
REQ-017 rise_o[i] and fall_o[i] SHALL be high for exactly one cycle per accepted change and SHALL never be high together.
REQ-018 change_o SHALL be registered, asserted in the same cycle as the rise_o/fall_o pulses.
REQ-019 Simultaneous accepted changes on several bits SHALL produce their pulses in the same cycle; change_o is then a single-cycle pulse.
REQ-020 cnt SHALL never wrap; the value DebounceCycles-1 is the terminal count.
REQ-021 With DebounceCycles == 1, a change on s2 SHALL be accepted on the first compare edge (pure synchroniser plus one register).

Reset
REQ-022 While rst_sys_i is high at a clock edge: s1, s2 and db_o <= ResetValue; all cnt <= 0; rise_o, fall_o, change_o <= 0; raw_i ignored.
REQ-023 Reset asserted mid-count SHALL discard the count; no pulse SHALL appear in any cycle at or after reset release unless a new full debounce completes.
REQ-024 Reset of the synchronisers to ResetValue SHALL prevent a spurious pulse after reset release when raw_i equals ResetValue.

Verification (Width=8, DebounceCycles=4, ResetValue=0)
REQ-025 Reset with raw_i=0x00 for 3 cycles, then release -> db_o=0x00; rise_o, fall_o and change_o stay 0 for 20 cycles.
REQ-026 raw_i 0x00->0x01 held -> db_o=0x01 at edge E5 (6th edge from capture); rise_o=0x01 and change_o=1 for exactly that cycle.
REQ-027 bit3 high for 3 cycles then low -> db_o, rise_o and fall_o unchanged; cnt[3] back to 0.
REQ-028 From db_o=0x80, raw_i->0x01 in one cycle -> on the same edge db_o=0x01, rise_o=0x01, fall_o=0x80, and a single-cycle change_o.
REQ-029 bit0 toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one rise_o[0] pulse, DebounceCycles+2 edges after the final transition is captured.
REQ-030 rst_sys_i pulsed while cnt[2]==2 with raw_i[2]=1 held -> db_o[2]=0 after the reset edge; rise_o[2] asserts only DebounceCycles+2 edges after release.
